canon_voice_mixer: RTL
======================

Name: canon_voice_mixer

Overview:
- Four-voice square-wave synthesiser and mixer between the note sequencer and the PWM audio output stage.
- Consumes the sequencer's time-multiplexed divider bus: one voice per clock, selected by the 2-bit slot index (cello = slot 0, violins = slots 1..3).
- Produces one registered 8-bit unsigned sample for the PWM stage.
- Each voice has a retriggerable decaying envelope, triggered from the crotchet pulse or from per-voice note starts.

Parameters:
- DECAY_SHIFT, 18: width of the free-running decay prescaler. One decay tick every 2^DECAY_SHIFT clocks.
- ENV_FLOOR, 4: sustain level. Decay never takes an envelope below this value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- slot  in  2  voice index that owns the divider bus this cycle
- divider  in  12  half-period for voice `slot`, in own-slot ticks; 0 = mute
- trig  in  4  per-voice envelope retrigger, one-cycle pulses
- sample  out  8  mixed unsigned sample, registered
- gate  out  4  current square-wave level per voice
- voice_en  out  4  1 = voice's last sampled divider was non-zero

Interface decision: reset rst_n, synchronous, active-low; clock clk.

Behaviour:
- Reset (synchronous, rst_n low at clk edge):
  - ph[0..3] = 0 (12-bit phase counters), gate = 0, env[0..3] = 0, voice_en = 0, sample = 0, prescaler = 0.
  - Reset applied mid-tone clears all state at the next edge, with no partial frame.
- Oscillator: only voice v = slot is updated each clock. Other voices hold.
  - divider == 0: ph[v] <= 0, gate[v] <= 0, voice_en[v] <= 0.
  - Else, if ph[v] >= divider-1: ph[v] <= 0, gate[v] toggles, voice_en[v] <= 1.
  - Else: ph[v] <= ph[v]+1, voice_en[v] <= 1.
  - Compare is ">=", not "==". If the divider shrinks below the current ph, the voice wraps and toggles on its next own slot; it never runs through a 4096-count wrap.
  - Tone period = 8*divider clocks when slot cycles 0,1,2,3.
- Envelope (independent of slot):
  - Prescaler increments every clock; a decay tick occurs when it wraps to 0.
  - Priority per voice: trig[v] → env <= 15. Otherwise decay tick and env > ENV_FLOOR → env <= env-1. Otherwise hold.
  - Trig coincident with a decay tick: trig wins, env = 15.
  - env at or below ENV_FLOOR never decays. After reset, env stays 0 until the first trig.
- Mix:
  - Term[v] = gate[v] ? {env[v],2'b00} : 0. Max 60 per voice.
  - sample <= term[0]+term[1]+term[2]+term[3], registered every clock, 1-cycle latency from gate/env.
  - Max sum is 240, so no saturation logic is needed. Compute the sum at 8 bits; the top-bit carry is provably zero.
- Slot sequence: slot is not required to be monotonic. The block does no checking; whichever voice slot names is updated.

Decomposition:
- Shared package canon_audio_pkg:
  - NUM_VOICES = 4, SLOT_W = 2, DIV_W = 12, ENV_W = 4, ENV_MAX = 15, SAMPLE_W = 8.
  - Slot constants CELLO_SLOT = 0, VIOLIN1..3_SLOT = 1..3.
- One sub-module: canon_voice_env, a per-voice envelope register with trig/tick/floor logic, instantiated four times.
- The oscillator array, prescaler and adder tree stay in the top level.

Test Plan:
- Reset: rst_n low 3 cycles, random divider/slot/trig → sample = 0, gate = 0, voice_en = 0 on every cycle; first post-reset sample = 0.
- Single tone: DECAY_SHIFT = 4, slot cycling 0..3, divider = 3 on slot 0 and 0 elsewhere, trig = 0001 once.
  - gate[0] toggles every 12 clocks.
  - sample alternates 60/0.
  - env steps down 1 per 16 clocks to 4, then holds; the high level settles at 16.
- Mute mid-tone: voice 2 running at divider 5, then divider = 0 at slot 2 → gate[2] = 0 and voice_en[2] = 0 after that edge; sample drops by voice 2's term one cycle later.
- Divider shrink: voice 1 with ph = 10, then divider = 4 at slot 1 → ph[1] = 0 and gate[1] toggles at that edge (no 4096-cycle stall).
- Full load: all dividers = 1, trig = 1111 once, long DECAY_SHIFT.
  - Each gate toggles on its own slot.
  - sample reaches 240 exactly once per 8 clocks and never wraps.
- Collision and reset: trig[3] asserted on a decay-tick cycle → env[3] = 15; rst_n low mid-tone → all outputs 0 at the next edge.

Source files
------------

// File: rtl/canon_audio_pkg.sv
// Shared constants and helpers for the canon audio path: voice count, bus widths,
// envelope range and the slot numbering used by the note sequencer.
package canon_audio_pkg;

  localparam int NUM_VOICES = 4;
  localparam int SLOT_W     = 2;
  localparam int DIV_W      = 12;
  localparam int ENV_W      = 4;
  localparam int SAMPLE_W   = 8;

  localparam logic [ENV_W-1:0] ENV_MAX = 4'd15;

  localparam logic [SLOT_W-1:0] CELLO_SLOT   = 2'd0;
  localparam logic [SLOT_W-1:0] VIOLIN1_SLOT = 2'd1;
  localparam logic [SLOT_W-1:0] VIOLIN2_SLOT = 2'd2;
  localparam logic [SLOT_W-1:0] VIOLIN3_SLOT = 2'd3;

  // A sounding voice contributes env*4 (at most 60), so four voices top out at 240.
  function automatic logic [SAMPLE_W-1:0] voice_term(input logic g,
                                                     input logic [ENV_W-1:0] env);
    return g ? {2'b00, env, 2'b00} : '0;
  endfunction

endpackage

// File: rtl/canon_voice_env.sv
// Per-voice decaying envelope: retrigger to full scale, step down one unit per
// decay tick, and never fall below the sustain floor.
module canon_voice_env
  import canon_audio_pkg::*;
#(
  parameter int ENV_FLOOR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             tick,
  output logic [ENV_W-1:0] env
);

  localparam logic [ENV_W-1:0] FLOOR = ENV_W'(ENV_FLOOR);

  // Retrigger outranks a coincident decay tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      env <= '0;
    end else if (trig) begin
      env <= ENV_MAX;
    end else if (tick && (env > FLOOR)) begin
      env <= env - ENV_W'(1);
    end
  end

endmodule

// File: rtl/canon_voice_mixer.sv
// Four-voice square-wave synthesiser fed by the sequencer's time-multiplexed
// divider bus, with per-voice decaying envelopes mixed into one 8-bit sample.
module canon_voice_mixer
  import canon_audio_pkg::*;
#(
  parameter int DECAY_SHIFT = 18,
  parameter int ENV_FLOOR   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SLOT_W-1:0]     slot,
  input  logic [DIV_W-1:0]      divider,
  input  logic [NUM_VOICES-1:0] trig,
  output logic [SAMPLE_W-1:0]   sample,
  output logic [NUM_VOICES-1:0] gate,
  output logic [NUM_VOICES-1:0] voice_en
);

  // Bus semantics: there is no handshake. Every clock the (slot, divider) pair is
  // valid and owned by voice `slot`; the block always accepts it and updates only
  // that voice's oscillator. Slot order is whatever the sequencer chooses.

  logic [DIV_W-1:0]       ph [NUM_VOICES];
  logic [DIV_W-1:0]       ph_cur;
  logic [DIV_W-1:0]       div_last;
  logic [DECAY_SHIFT-1:0] prescaler;
  logic                   tick;
  logic [ENV_W-1:0]       env [NUM_VOICES];
  logic [SAMPLE_W-1:0]    mix;

  assign ph_cur   = ph[slot];
  assign div_last = divider - DIV_W'(1);

  // The tick coincides with the edge on which the prescaler wraps back to zero.
  assign tick = (prescaler == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + DECAY_SHIFT'(1);
    end
  end

  // ">=" rather than "==" so a shrinking divider wraps on the next own slot
  // instead of counting all the way round the 12-bit phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) ph[v] <= '0;
      gate     <= '0;
      voice_en <= '0;
    end else if (divider == '0) begin
      ph[slot]       <= '0;
      gate[slot]     <= 1'b0;
      voice_en[slot] <= 1'b0;
    end else if (ph_cur >= div_last) begin
      ph[slot]       <= '0;
      gate[slot]     <= ~gate[slot];
      voice_en[slot] <= 1'b1;
    end else begin
      ph[slot]       <= ph_cur + DIV_W'(1);
      voice_en[slot] <= 1'b1;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    canon_voice_env #(
      .ENV_FLOOR(ENV_FLOOR)
    ) u_env (
      .clk   (clk),
      .rst_n (rst_n),
      .trig  (trig[v]),
      .tick  (tick),
      .env   (env[v])
    );
  end

  // 8-bit sum cannot carry out: four terms of at most 60 each.
  always_comb begin
    mix = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix = mix + voice_term(gate[v], env[v]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample <= '0;
    end else begin
      sample <= mix;
    end
  end

endmodule
